decode_stage_hs: RTL and testbench
==================================

// Module: decode_stage_hs
// PURPOSE
//  Next-generation MIPS decode stage: a valid/allowin handshaked pipeline slot between fetch and execute.
//  Holds the fetched instruction in an internal slot (ds), decodes it and issues registered controls to exe.
//  Supports load-use interlock, exe back-pressure and whole-pipe flush.
//  Replaces raw-stall gating with per-slot valid bits.
// PARAMETERS
//  DATA_W      32  datapath/PC width (>=32; extends zero-extended above bit 31)
//  REG_AW       5  register address width
//  ALUOP_W      4  ALU opcode width
//  WEN_W  DATA_W/8 byte write-enable width
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous, active-high reset
//  flush           in   1        squash ds and output slots
//  fe_valid        in   1        fetch offers instruction
//  fe_inst         in   32       instruction word
//  fe_pc           in   DATA_W   instruction PC
//  de_allowin      out  1        decode can accept this cycle
//  de_rs_addr      out  REG_AW   rs of ds instruction (0 if unused)
//  de_rt_addr      out  REG_AW   rt of ds instruction (0 if unused)
//  de_rs_data      in   DATA_W   forwarded rs value
//  de_rt_data      in   DATA_W   forwarded rt value
//  hazard_stall    in   1        operand not yet available (load-use)
//  de_br_fire      out  1        one-cycle pulse: branch/jump issued
//  de_br_kind      out  2        0 b-type,1 j/jal,2 jr/jalr
//  de_b_type       out  4        BNE0 BEQ1 BGEZ2 BGTZ3 BLEZ4 BLTZ5 BLTZAL6 BGEZAL7
//  de_b_offset     out  16       branch offset; de_j_index out 26 jump index
//  exe_allowin     in   1        exe can accept
//  de_out_valid    out  1        output registers hold valid op
//  de_pc_out       out  DATA_W   PC of issued op
//  de_aluop        out  ALUOP_W  AND0 OR1 ADD2 SUB3 SLT4 SLTU5 SLL6 SRL7 SRA9 LUI10 XOR11 NOR12
//  de_alusrc1/2    out  DATA_W   ALU operands
//  de_mem_en, de_mem_read out 1; de_mem_wen out WEN_W; de_mem_wdata out DATA_W
//  de_reg_en       out  1;   de_reg_waddr  out REG_AW
// BEHAVIOUR
//  - Reset: ds_valid=0, de_out_valid=0, every registered output 0; de_allowin=1 after reset.
//  - ds_ready_go = ~hazard_stall; de_allowin = ~ds_valid | (ds_ready_go & exe_allowin).
//  - fe accept: fe_valid & de_allowin & ~flush -> ds_inst/ds_pc loaded, ds_valid=1 next edge.
//  - ds leaves when ds_valid & ds_ready_go & exe_allowin; new accept in same cycle allowed (full throughput).
//  - Output regs load when exe_allowin: de_out_valid <= ds_valid & ds_ready_go; payload from decode of ds.
//  - exe_allowin=0: output regs and ds hold unchanged; hazard_stall=1 with exe_allowin=1 inserts a bubble (out_valid=0).
//  - Latency: accept at edge N -> de_out_valid at edge N+1 (no stall).
//  - de_reg_en, de_mem_wen, de_mem_en forced 0 whenever the loaded op is not valid.
//  - de_br_fire = ds_valid & ds_ready_go & exe_allowin & is_branch_or_jump & ~flush (combinational, once per instr).
//  - Decode: R-type arith/logic/shift/JR/JALR, ADDI(U) SLTI(U) ANDI ORI XORI LUI LW SW, J JAL, all 8 branches.
//    src1: sa zero-ext for SLL/SRL/SRA; ds_pc for JAL/JALR/BxxZAL; else rs. src2: rt (R); zero-ext imm
//    (ANDI/ORI/XORI); 8 (links); sign-ext imm (others). waddr: rd (R/JALR), 31 (JAL/BxxZAL), rt (I-type).
//    SW: mem_wen all ones, wdata=rt. LW: mem_read=1. JR/branches/J/SW: reg_en=0.
//  - Unknown encodings decode as NOP (no writes).
//  - flush: ds_valid and de_out_valid cleared next edge; wins over simultaneous accept/issue; de_br_fire 0.
//  - Reset asserted mid-operation: all state cleared immediately (async), in-flight ops lost.
// CONFIGURATION
//  DECODE_RI_EXC_EN defined: adds out port de_exc_ri (registered with payload); unknown opcode/func
//   -> de_exc_ri=1 with reg_en/mem_wen/mem_en=0, de_br_fire=0. Not defined: port absent, unknown = NOP.
// TESTING
//  - ADDIU $2,$1,5 (0x24220005), rs_data=10 -> next edge: out_valid=1, aluop=2, src1=10, src2=5, reg_en=1, waddr=2.
//  - SW $3,8($2) (0xAC430008), rs=0x100, rt=0xDEADBEEF -> mem_wen=4'hF, mem_en=1, src2=8, wdata=0xDEADBEEF, reg_en=0.
//  - JAL at pc 0xBFC00000 -> de_br_fire=1 one cycle, kind=1; out: src1=0xBFC00000, src2=8, waddr=31.
//  - hazard_stall=1 for 2 cycles -> de_allowin=0, two bubbles (out_valid=0), then op issues; exe_allowin=0 holds outputs 3 cycles.
//  - flush coincident with fe_valid and ds issue -> next edge ds_valid=0, out_valid=0, no reg_en/mem_wen; reset pulse mid-stream same.
//  - DECODE_RI_EXC_EN: inst 0xFC000000 -> de_exc_ri=1, reg_en=0; without macro -> NOP, out_valid=1.

Source files
------------

// File: rtl/decode_stage_hs.sv
// -----------------------------------------------------------------------------
// decode_stage_hs
// MIPS decode stage with a valid/allowin handshake between fetch and execute.
// One instruction slot (ds) holds the fetched word. It is decoded
// combinationally, and the controls are registered towards exe. The stage
// supports a load-use interlock (hazard_stall), exe back-pressure (exe_allowin)
// and a whole-pipe flush.
//
// Build option:
//   DECODE_RI_EXC_EN  adds output de_exc_ri. An unknown opcode or funct field
//                     raises a reserved-instruction flag instead of a silent NOP.
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   flush                    squash ds and the output registers
//   fe_valid/fe_inst/fe_pc   instruction offered by fetch
//   de_allowin               decode can accept this cycle
//   de_rs_addr/de_rt_addr    source registers of ds (0 when unused or empty)
//   de_rs_data/de_rt_data    forwarded operand values
//   hazard_stall             operand not yet available
//   de_br_fire               one-cycle pulse when a branch/jump issues
//   de_br_kind/de_b_type     branch class and b-type condition
//   de_b_offset/de_j_index   raw offset / jump index fields
//   exe_allowin              exe can accept
//   de_out_valid ...         registered op for exe (pc, aluop, operands,
//   de_reg_waddr             memory controls, register write-back)
// -----------------------------------------------------------------------------
module decode_stage_hs #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int WEN_W   = DATA_W / 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               fe_valid,
    input  logic [31:0]        fe_inst,
    input  logic [DATA_W-1:0]  fe_pc,
    output logic               de_allowin,
    output logic [REG_AW-1:0]  de_rs_addr,
    output logic [REG_AW-1:0]  de_rt_addr,
    input  logic [DATA_W-1:0]  de_rs_data,
    input  logic [DATA_W-1:0]  de_rt_data,
    input  logic               hazard_stall,
    output logic               de_br_fire,
    output logic [1:0]         de_br_kind,
    output logic [3:0]         de_b_type,
    output logic [15:0]        de_b_offset,
    output logic [25:0]        de_j_index,
    input  logic               exe_allowin,
    output logic               de_out_valid,
    output logic [DATA_W-1:0]  de_pc_out,
    output logic [ALUOP_W-1:0] de_aluop,
    output logic [DATA_W-1:0]  de_alusrc1,
    output logic [DATA_W-1:0]  de_alusrc2,
    output logic               de_mem_en,
    output logic               de_mem_read,
    output logic [WEN_W-1:0]   de_mem_wen,
    output logic [DATA_W-1:0]  de_mem_wdata,
    output logic               de_reg_en,
    output logic [REG_AW-1:0]  de_reg_waddr
`ifdef DECODE_RI_EXC_EN
    ,
    output logic               de_exc_ri
`endif
);

    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(12);

    typedef enum logic [1:0] {S1_RS, S1_SA, S1_PC} src1_sel_e;
    typedef enum logic [1:0] {S2_RT, S2_ZIMM, S2_LINK, S2_SIMM} src2_sel_e;
    typedef enum logic [1:0] {WA_RD, WA_R31, WA_RT} wsel_e;

    // 32-bit quantities are zero-extended into wider datapaths.
    function automatic logic [DATA_W-1:0] ext32(input logic [31:0] v);
        return DATA_W'(v);
    endfunction

    // Decode slot (ds)
    logic              vld_p0;
    logic [31:0]       ds_inst_p0;
    logic [DATA_W-1:0] ds_pc_p0;

    logic ds_ready_go;
    logic accept;
    logic issue_vld;

    assign ds_ready_go = ~hazard_stall;
    assign de_allowin  = ~vld_p0 | (ds_ready_go & exe_allowin);
    assign accept      = fe_valid & de_allowin & ~flush;
    assign issue_vld   = vld_p0 & ds_ready_go;

    // Instruction fields
    logic [5:0]        op, fn;
    logic [4:0]        rs_f, rt_f, rd_f, sa_f;
    logic signed [15:0] imm_s;
    logic [31:0]       simm32, zimm32;

    assign op     = ds_inst_p0[31:26];
    assign rs_f   = ds_inst_p0[25:21];
    assign rt_f   = ds_inst_p0[20:16];
    assign rd_f   = ds_inst_p0[15:11];
    assign sa_f   = ds_inst_p0[10:6];
    assign fn     = ds_inst_p0[5:0];
    assign imm_s  = signed'(ds_inst_p0[15:0]);
    assign simm32 = 32'(imm_s);   // signed source: the size cast sign-extends
    assign zimm32 = {16'd0, ds_inst_p0[15:0]};

    // Decoded controls
    logic               d_known, d_is_br, d_use_rs, d_use_rt;
    logic [1:0]         d_br_kind;
    logic [3:0]         d_b_type;
    logic [ALUOP_W-1:0] d_aluop;
    src1_sel_e          d_s1;
    src2_sel_e          d_s2;
    wsel_e              d_wsel;
    logic               d_reg_en, d_mem_en, d_mem_read, d_mem_we;

    always_comb begin
        d_known    = 1'b1;
        d_is_br    = 1'b0;
        d_br_kind  = 2'd0;
        d_b_type   = 4'd0;
        d_use_rs   = 1'b1;
        d_use_rt   = 1'b0;
        d_aluop    = ALU_ADD;
        d_s1       = S1_RS;
        d_s2       = S2_SIMM;
        d_wsel     = WA_RT;
        d_reg_en   = 1'b0;
        d_mem_en   = 1'b0;
        d_mem_read = 1'b0;
        d_mem_we   = 1'b0;
        case (op)
            6'h00: begin
                d_s2     = S2_RT;
                d_wsel   = WA_RD;
                d_use_rt = 1'b1;
                d_reg_en = 1'b1;
                case (fn)
                    6'h20, 6'h21: d_aluop = ALU_ADD;
                    6'h22, 6'h23: d_aluop = ALU_SUB;
                    6'h24:        d_aluop = ALU_AND;
                    6'h25:        d_aluop = ALU_OR;
                    6'h26:        d_aluop = ALU_XOR;
                    6'h27:        d_aluop = ALU_NOR;
                    6'h2A:        d_aluop = ALU_SLT;
                    6'h2B:        d_aluop = ALU_SLTU;
                    6'h00: begin d_aluop = ALU_SLL; d_s1 = S1_SA; d_use_rs = 1'b0; end
                    6'h02: begin d_aluop = ALU_SRL; d_s1 = S1_SA; d_use_rs = 1'b0; end
                    6'h03: begin d_aluop = ALU_SRA; d_s1 = S1_SA; d_use_rs = 1'b0; end
                    6'h08: begin   // JR
                        d_use_rt  = 1'b0;
                        d_reg_en  = 1'b0;
                        d_is_br   = 1'b1;
                        d_br_kind = 2'd2;
                    end
                    6'h09: begin   // JALR
                        d_use_rt  = 1'b0;
                        d_s1      = S1_PC;
                        d_s2      = S2_LINK;
                        d_is_br   = 1'b1;
                        d_br_kind = 2'd2;
                    end
                    default: d_known = 1'b0;
                endcase
            end
            6'h01: begin   // REGIMM: the condition lives in the rt field
                d_is_br = 1'b1;
                case (rt_f)
                    5'h00: d_b_type = 4'd5;
                    5'h01: d_b_type = 4'd2;
                    5'h10: d_b_type = 4'd6;
                    5'h11: d_b_type = 4'd7;
                    default: d_known = 1'b0;
                endcase
                if (rt_f[4]) begin   // link variants
                    d_s1     = S1_PC;
                    d_s2     = S2_LINK;
                    d_wsel   = WA_R31;
                    d_reg_en = 1'b1;
                end
            end
            6'h02: begin d_is_br = 1'b1; d_br_kind = 2'd1; d_use_rs = 1'b0; end
            6'h03: begin
                d_is_br   = 1'b1;
                d_br_kind = 2'd1;
                d_use_rs  = 1'b0;
                d_s1      = S1_PC;
                d_s2      = S2_LINK;
                d_wsel    = WA_R31;
                d_reg_en  = 1'b1;
            end
            6'h04: begin d_is_br = 1'b1; d_b_type = 4'd1; d_use_rt = 1'b1; end
            6'h05: begin d_is_br = 1'b1; d_b_type = 4'd0; d_use_rt = 1'b1; end
            6'h06: begin d_is_br = 1'b1; d_b_type = 4'd4; end
            6'h07: begin d_is_br = 1'b1; d_b_type = 4'd3; end
            6'h08, 6'h09: d_reg_en = 1'b1;
            6'h0A: begin d_reg_en = 1'b1; d_aluop = ALU_SLT;  end
            6'h0B: begin d_reg_en = 1'b1; d_aluop = ALU_SLTU; end
            6'h0C: begin d_reg_en = 1'b1; d_aluop = ALU_AND; d_s2 = S2_ZIMM; end
            6'h0D: begin d_reg_en = 1'b1; d_aluop = ALU_OR;  d_s2 = S2_ZIMM; end
            6'h0E: begin d_reg_en = 1'b1; d_aluop = ALU_XOR; d_s2 = S2_ZIMM; end
            6'h0F: begin d_reg_en = 1'b1; d_aluop = ALU_LUI; d_use_rs = 1'b0; end
            6'h23: begin d_reg_en = 1'b1; d_mem_en = 1'b1; d_mem_read = 1'b1; end
            6'h2B: begin d_mem_en = 1'b1; d_mem_we = 1'b1; d_use_rt = 1'b1; end
            default: d_known = 1'b0;
        endcase
        // Unknown encodings must have no side effects at all.
        if (!d_known) begin
            d_is_br    = 1'b0;
            d_use_rs   = 1'b0;
            d_use_rt   = 1'b0;
            d_reg_en   = 1'b0;
            d_mem_en   = 1'b0;
            d_mem_read = 1'b0;
            d_mem_we   = 1'b0;
        end
    end

    logic [DATA_W-1:0] src1, src2;
    logic [REG_AW-1:0] waddr;

    always_comb begin
        case (d_s1)
            S1_SA:   src1 = ext32({27'd0, sa_f});
            S1_PC:   src1 = ds_pc_p0;
            default: src1 = de_rs_data;
        endcase
        case (d_s2)
            S2_RT:   src2 = de_rt_data;
            S2_ZIMM: src2 = ext32(zimm32);
            S2_LINK: src2 = ext32(32'd8);
            default: src2 = ext32(simm32);
        endcase
        case (d_wsel)
            WA_RD:   waddr = REG_AW'(rd_f);
            WA_R31:  waddr = REG_AW'(5'd31);
            default: waddr = REG_AW'(rt_f);
        endcase
    end

    assign de_rs_addr  = (vld_p0 & d_use_rs) ? REG_AW'(rs_f) : '0;
    assign de_rt_addr  = (vld_p0 & d_use_rt) ? REG_AW'(rt_f) : '0;
    assign de_br_fire  = issue_vld & exe_allowin & d_is_br & ~flush;
    assign de_br_kind  = d_br_kind;
    assign de_b_type   = d_b_type;
    assign de_b_offset = ds_inst_p0[15:0];
    assign de_j_index  = ds_inst_p0[25:0];

    // ---- fetch -> ds boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            ds_inst_p0 <= '0;
            ds_pc_p0   <= '0;
        end else begin
            // With allowin high the slot is free or draining this cycle,
            // so its next state is simply whatever fetch offers.
            if (flush)
                vld_p0 <= 1'b0;
            else if (de_allowin)
                vld_p0 <= fe_valid;
            if (accept) begin
                ds_inst_p0 <= fe_inst;
                ds_pc_p0   <= fe_pc;
            end
        end
    end

    logic exc_ri_p1;

    // ---- ds -> exe boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_out_valid <= 1'b0;
            de_pc_out    <= '0;
            de_aluop     <= '0;
            de_alusrc1   <= '0;
            de_alusrc2   <= '0;
            de_mem_en    <= 1'b0;
            de_mem_read  <= 1'b0;
            de_mem_wen   <= '0;
            de_mem_wdata <= '0;
            de_reg_en    <= 1'b0;
            de_reg_waddr <= '0;
            exc_ri_p1    <= 1'b0;
        end else if (flush) begin
            de_out_valid <= 1'b0;
            de_mem_en    <= 1'b0;
            de_mem_read  <= 1'b0;
            de_mem_wen   <= '0;
            de_reg_en    <= 1'b0;
            exc_ri_p1    <= 1'b0;
        end else if (exe_allowin) begin
            de_out_valid <= issue_vld;
            de_pc_out    <= ds_pc_p0;
            de_aluop     <= d_aluop;
            de_alusrc1   <= src1;
            de_alusrc2   <= src2;
            de_mem_en    <= issue_vld & d_mem_en;
            de_mem_read  <= issue_vld & d_mem_read;
            de_mem_wen   <= (issue_vld & d_mem_we) ? '1 : '0;
            de_mem_wdata <= d_mem_we ? de_rt_data : '0;
            de_reg_en    <= issue_vld & d_reg_en;
            de_reg_waddr <= waddr;
            exc_ri_p1    <= issue_vld & ~d_known;
        end
    end

`ifdef DECODE_RI_EXC_EN
    assign de_exc_ri = exc_ri_p1;
`else
    logic unused_exc;
    assign unused_exc = exc_ri_p1;
`endif

endmodule

// File: tb/tb_decode_stage_hs.sv
module tb_decode_stage_hs;
    localparam int DATA_W = 32, REG_AW = 5, ALUOP_W = 4, WEN_W = 4;

    logic clk = 1'b0;
    logic reset, flush, fe_valid, hazard_stall, exe_allowin;
    logic [31:0] fe_inst, fe_pc, de_rs_data, de_rt_data;
    logic de_allowin, de_br_fire, de_out_valid, de_mem_en, de_mem_read, de_reg_en;
    logic [4:0] de_rs_addr, de_rt_addr, de_reg_waddr;
    logic [1:0] de_br_kind;
    logic [3:0] de_b_type, de_aluop, de_mem_wen;
    logic [15:0] de_b_offset;
    logic [25:0] de_j_index;
    logic [31:0] de_pc_out, de_alusrc1, de_alusrc2, de_mem_wdata;
`ifdef DECODE_RI_EXC_EN
    logic de_exc_ri;
`endif

    always #5 clk = ~clk;

    decode_stage_hs #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .WEN_W(WEN_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .fe_valid(fe_valid), .fe_inst(fe_inst),
        .fe_pc(fe_pc), .de_allowin(de_allowin), .de_rs_addr(de_rs_addr), .de_rt_addr(de_rt_addr),
        .de_rs_data(de_rs_data), .de_rt_data(de_rt_data), .hazard_stall(hazard_stall),
        .de_br_fire(de_br_fire), .de_br_kind(de_br_kind), .de_b_type(de_b_type),
        .de_b_offset(de_b_offset), .de_j_index(de_j_index), .exe_allowin(exe_allowin),
        .de_out_valid(de_out_valid), .de_pc_out(de_pc_out), .de_aluop(de_aluop),
        .de_alusrc1(de_alusrc1), .de_alusrc2(de_alusrc2), .de_mem_en(de_mem_en),
        .de_mem_read(de_mem_read), .de_mem_wen(de_mem_wen), .de_mem_wdata(de_mem_wdata),
        .de_reg_en(de_reg_en), .de_reg_waddr(de_reg_waddr)
`ifdef DECODE_RI_EXC_EN
        , .de_exc_ri(de_exc_ri)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_BAD, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                  M_SLL, M_SRL, M_SRA, M_JR, M_JALR, M_ADDI, M_SLTI, M_SLTIU,
                  M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_J, M_JAL,
                  M_BNE, M_BEQ, M_BGEZ, M_BGTZ, M_BLEZ, M_BLTZ, M_BLTZAL, M_BGEZAL} mn_e;

    typedef struct {
        bit valid; bit bad_op; logic [31:0] pc; logic [3:0] aluop;
        logic [31:0] s1, s2; bit mem_en, mem_read; logic [3:0] wen;
        logic [31:0] wdata; bit reg_en; logic [4:0] waddr; bit exc;
    } out_t;

    function automatic mn_e classify(input logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h20, 6'h21: return M_ADD;
                6'h22, 6'h23: return M_SUB;
                6'h24: return M_AND;  6'h25: return M_OR;
                6'h26: return M_XOR;  6'h27: return M_NOR;
                6'h2A: return M_SLT;  6'h2B: return M_SLTU;
                6'h00: return M_SLL;  6'h02: return M_SRL;
                6'h03: return M_SRA;  6'h08: return M_JR;
                6'h09: return M_JALR;
                default: return M_BAD;
            endcase
            6'h01: case (i[20:16])
                5'h00: return M_BLTZ;   5'h01: return M_BGEZ;
                5'h10: return M_BLTZAL; 5'h11: return M_BGEZAL;
                default: return M_BAD;
            endcase
            6'h02: return M_J;    6'h03: return M_JAL;
            6'h04: return M_BEQ;  6'h05: return M_BNE;
            6'h06: return M_BLEZ; 6'h07: return M_BGTZ;
            6'h08, 6'h09: return M_ADDI;
            6'h0A: return M_SLTI; 6'h0B: return M_SLTIU;
            6'h0C: return M_ANDI; 6'h0D: return M_ORI;
            6'h0E: return M_XORI; 6'h0F: return M_LUI;
            6'h23: return M_LW;   6'h2B: return M_SW;
            default: return M_BAD;
        endcase
    endfunction

    function automatic bit is_link(mn_e m);
        return m inside {M_JAL, M_JALR, M_BLTZAL, M_BGEZAL};
    endfunction
    function automatic bit is_rtype(mn_e m);
        return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                         M_SLL, M_SRL, M_SRA, M_JR, M_JALR};
    endfunction
    function automatic bit is_branch(mn_e m);
        return m inside {M_JR, M_JALR, M_J, M_JAL, M_BNE, M_BEQ, M_BGEZ, M_BGTZ,
                         M_BLEZ, M_BLTZ, M_BLTZAL, M_BGEZAL};
    endfunction
    function automatic int br_kind(mn_e m);
        if (m inside {M_J, M_JAL}) return 1;
        if (m inside {M_JR, M_JALR}) return 2;
        return 0;
    endfunction
    function automatic int b_code(mn_e m);
        case (m)
            M_BNE: return 0;  M_BEQ: return 1;  M_BGEZ: return 2;   M_BGTZ: return 3;
            M_BLEZ: return 4; M_BLTZ: return 5; M_BLTZAL: return 6; M_BGEZAL: return 7;
            default: return 0;
        endcase
    endfunction
    function automatic bit uses_rs(mn_e m);
        return !(m inside {M_BAD, M_SLL, M_SRL, M_SRA, M_LUI, M_J, M_JAL});
    endfunction
    function automatic bit uses_rt(mn_e m);
        return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                         M_SLL, M_SRL, M_SRA, M_SW, M_BEQ, M_BNE};
    endfunction
    function automatic bit writes_reg(mn_e m);
        return !(m inside {M_BAD, M_JR, M_J, M_SW, M_BNE, M_BEQ, M_BGEZ, M_BGTZ,
                           M_BLEZ, M_BLTZ});
    endfunction
    function automatic logic [3:0] alu_of(mn_e m);
        case (m)
            M_AND, M_ANDI: return 4'd0;
            M_OR, M_ORI:   return 4'd1;
            M_SUB:         return 4'd3;
            M_SLT, M_SLTI: return 4'd4;
            M_SLTU, M_SLTIU: return 4'd5;
            M_SLL: return 4'd6;  M_SRL: return 4'd7;  M_SRA: return 4'd9;
            M_LUI: return 4'd10;
            M_XOR, M_XORI: return 4'd11;
            M_NOR: return 4'd12;
            default: return 4'd2;
        endcase
    endfunction

    function automatic out_t ref_out(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] rsd, input logic [31:0] rtd);
        out_t o;
        mn_e m = classify(i);
        int simm = $signed(i[15:0]);
        o = '{default: 0};
        o.bad_op   = (m == M_BAD);
        o.pc       = pc;
        o.aluop    = alu_of(m);
        o.s1       = (m inside {M_SLL, M_SRL, M_SRA}) ? 32'(i[10:6]) : is_link(m) ? pc : rsd;
        o.s2       = is_link(m) ? 32'd8 : is_rtype(m) ? rtd :
                     (m inside {M_ANDI, M_ORI, M_XORI}) ? 32'(i[15:0]) : 32'(simm);
        o.reg_en   = writes_reg(m);
        o.waddr    = is_rtype(m) ? i[15:11] : is_link(m) ? 5'd31 : i[20:16];
        o.mem_en   = (m == M_LW) || (m == M_SW);
        o.mem_read = (m == M_LW);
        o.wen      = (m == M_SW) ? 4'hF : 4'h0;
        o.wdata    = (m == M_SW) ? rtd : 32'd0;
        o.exc      = (m == M_BAD);
        return o;
    endfunction

    bit          m_ds_vld;
    logic [31:0] m_ds_inst, m_ds_pc;
    out_t        m_out;

    task automatic model_reset();
        m_ds_vld = 0; m_ds_inst = '0; m_ds_pc = '0;
        m_out = '{default: 0};
    endtask

    task automatic drive(input bit fv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit hz, input bit ex, input bit fl,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        fe_valid = fv; fe_inst = inst; fe_pc = pc; hazard_stall = hz;
        exe_allowin = ex; flush = fl; de_rs_data = rsd; de_rt_data = rtd;
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle();
        mn_e m;
        bit allow, fire;
        #1;
        m     = classify(m_ds_inst);
        allow = !m_ds_vld || (!hazard_stall && exe_allowin);
        fire  = m_ds_vld && !hazard_stall && exe_allowin && is_branch(m) && !flush;
        chk("allowin", de_allowin, allow);
        chk("br_fire", de_br_fire, fire);
        chk("rs_addr", de_rs_addr, (m_ds_vld && uses_rs(m)) ? m_ds_inst[25:21] : 5'd0);
        chk("rt_addr", de_rt_addr, (m_ds_vld && uses_rt(m)) ? m_ds_inst[20:16] : 5'd0);
        if (fire) begin
            chk("br_kind", de_br_kind, br_kind(m));
            if (br_kind(m) == 0) begin
                chk("b_type", de_b_type, b_code(m));
                chk("b_offset", de_b_offset, m_ds_inst[15:0]);
            end
            if (br_kind(m) == 1) chk("j_index", de_j_index, m_ds_inst[25:0]);
        end
        if (flush) begin
            m_out.valid = 0; m_out.reg_en = 0; m_out.mem_en = 0;
            m_out.mem_read = 0; m_out.wen = 0; m_out.exc = 0;
        end else if (exe_allowin) begin
            m_out = ref_out(m_ds_inst, m_ds_pc, de_rs_data, de_rt_data);
            m_out.valid = m_ds_vld && !hazard_stall;
            if (!m_out.valid) begin
                m_out.reg_en = 0; m_out.mem_en = 0; m_out.mem_read = 0;
                m_out.wen = 0; m_out.exc = 0;
            end
        end
        if (flush) m_ds_vld = 0;
        else if (allow) begin
            m_ds_vld = fe_valid;
            if (fe_valid) begin m_ds_inst = fe_inst; m_ds_pc = fe_pc; end
        end
        @(posedge clk);
        #1;
        chk("out_valid", de_out_valid, m_out.valid);
        chk("reg_en", de_reg_en, m_out.reg_en);
        chk("mem_en", de_mem_en, m_out.mem_en);
        chk("mem_wen", de_mem_wen, m_out.wen);
`ifdef DECODE_RI_EXC_EN
        chk("exc_ri", de_exc_ri, m_out.exc);
`endif
        if (m_out.valid && !m_out.bad_op) begin
            chk("pc_out", de_pc_out, m_out.pc);
            chk("aluop", de_aluop, m_out.aluop);
            chk("src1", de_alusrc1, m_out.s1);
            chk("src2", de_alusrc2, m_out.s2);
            chk("waddr", de_reg_waddr, m_out.waddr);
            chk("mem_read", de_mem_read, m_out.mem_read);
            chk("wdata", de_mem_wdata, m_out.wdata);
        end
    endtask

    logic [5:0] optab [20] = '{6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fntab [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
    logic [4:0] rttab [4]  = '{5'h00, 5'h01, 5'h10, 5'h11};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 19) == 0) return r;
        r[31:26] = optab[$urandom_range(0, 19)];
        if (r[31:26] == 6'h00) r[5:0] = fntab[$urandom_range(0, 14)];
        if (r[31:26] == 6'h01) r[20:16] = rttab[$urandom_range(0, 3)];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", de_out_valid, 1'b0);
        chk("rst_reg_en", de_reg_en, 1'b0);
        chk("rst_mem_wen", de_mem_wen, 4'h0);
        chk("rst_pc_out", de_pc_out, 32'd0);
        chk("rst_src1", de_alusrc1, 32'd0);
        chk("rst_allowin", de_allowin, 1'b1);
        reset = 1'b0;

        // ADDIU $2,$1,5
        drive(1, 32'h24220005, 32'h1000, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd10, 32'd0); cycle();
        chk("addiu_valid", de_out_valid, 1'b1);
        chk("addiu_aluop", de_aluop, 4'd2);
        chk("addiu_src1", de_alusrc1, 32'd10);
        chk("addiu_src2", de_alusrc2, 32'd5);
        chk("addiu_reg_en", de_reg_en, 1'b1);
        chk("addiu_waddr", de_reg_waddr, 5'd2);

        // SW $3,8($2)
        drive(1, 32'hAC430008, 32'h1004, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'h100, 32'hDEADBEEF); cycle();
        chk("sw_wen", de_mem_wen, 4'hF);
        chk("sw_mem_en", de_mem_en, 1'b1);
        chk("sw_src2", de_alusrc2, 32'd8);
        chk("sw_wdata", de_mem_wdata, 32'hDEADBEEF);
        chk("sw_reg_en", de_reg_en, 1'b0);

        // JAL at 0xBFC00000
        drive(1, 32'h0C100000, 32'hBFC00000, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'h55, 32'h66);
        #1;
        chk("jal_fire", de_br_fire, 1'b1);
        chk("jal_kind", de_br_kind, 2'd1);
        cycle();
        chk("jal_src1", de_alusrc1, 32'hBFC00000);
        chk("jal_src2", de_alusrc2, 32'd8);
        chk("jal_waddr", de_reg_waddr, 5'd31);
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd0, 32'd0);
        #1;
        chk("jal_fire_once", de_br_fire, 1'b0);
        cycle();

        // ADDU $3,$1,$2 stalled two cycles, then exe back-pressure for three
        drive(1, 32'h00221821, 32'h2000, 0, 1, 0, 32'd0, 32'd0); cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h24220005, 32'h2100, 1, 1, 0, 32'd0, 32'd0);
            #1;
            chk("stall_allowin", de_allowin, 1'b0);
            cycle();
            chk("stall_bubble", de_out_valid, 1'b0);
        end
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd5, 32'd7); cycle();
        chk("addu_valid", de_out_valid, 1'b1);
        chk("addu_src2", de_alusrc2, 32'd7);
        chk("addu_waddr", de_reg_waddr, 5'd3);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h24220005, 32'h3000, 0, 0, 0, $urandom, $urandom); cycle();
            chk("hold_pc", de_pc_out, 32'h2000);
            chk("hold_valid", de_out_valid, 1'b1);
            chk("hold_src1", de_alusrc1, 32'd5);
        end
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd1, 32'd2); cycle();

        // flush coincident with accept and issue; flush also masks a branch fire
        drive(1, 32'h24220005, 32'h4000, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(1, 32'h00221821, 32'h4004, 0, 1, 1, 32'd0, 32'd0); cycle();
        chk("flush_valid", de_out_valid, 1'b0);
        chk("flush_reg_en", de_reg_en, 1'b0);
        drive(0, 32'd0, 32'd0, 1, 1, 0, 32'd0, 32'd0);
        #1;
        chk("flush_ds_empty", de_allowin, 1'b1);
        cycle();
        drive(1, 32'h0C000040, 32'h4100, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(0, 32'd0, 32'd0, 0, 1, 1, 32'd0, 32'd0);
        #1;
        chk("flush_no_fire", de_br_fire, 1'b0);
        cycle();
        chk("flush_jal_gone", de_reg_en, 1'b0);

        // reserved opcode
        drive(1, 32'hFC000000, 32'h5000, 0, 1, 0, 32'd0, 32'd0); cycle();
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd0, 32'd0); cycle();
        chk("ri_valid", de_out_valid, 1'b1);
        chk("ri_reg_en", de_reg_en, 1'b0);
        chk("ri_mem_en", de_mem_en, 1'b0);
`ifdef DECODE_RI_EXC_EN
        chk("ri_exc", de_exc_ri, 1'b1);
`endif

        // asynchronous reset in the middle of traffic
        drive(1, 32'h24220005, 32'h6000, 0, 1, 0, 32'd3, 32'd0); cycle();
        drive(1, 32'h24220005, 32'h6004, 0, 1, 0, 32'd3, 32'd0); cycle();
        reset = 1'b1;
        #1;
        chk("arst_valid", de_out_valid, 1'b0);
        chk("arst_reg_en", de_reg_en, 1'b0);
        chk("arst_rs_addr", de_rs_addr, 5'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 32'd0, 32'd0, 0, 1, 0, 32'd0, 32'd0); cycle();
        chk("arst_lost", de_out_valid, 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 19) == 0, $urandom, $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
